aurora_reset_sequencer: RTL and testbench

- Generates the Aurora 8b10b power-up and re-initialisation reset sequence: GT reset (pma_init) first, then core reset, with deassertion ordered GT first, core second.
- Sits beside the Aurora core wrapper on the init clock domain, driven by the conditioned board reset.
- Monitors channel_up, reports link status, and counts link drops.
- Produces resets for the core; it does not filter incoming ones.

---
 rtl/aurora_reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_aurora_reset_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aurora_reset_sequencer.sv
// Aurora 8b10b reset sequencer: releases pma_init first, then the core reset, then watches channel_up.
// Optional watchdog retry when the link does not come up: define AURORA_RST_WATCHDOG_EN.
module aurora_reset_sequencer #(
   parameter int PMA_HOLD   = 128,
   parameter int SYS_HOLD   = 64,
   parameter int WD_TIMEOUT = 65535,
   parameter int CNT_W      = 16
) (
   input  logic       CLK,
   input  logic       rst_in,
   input  logic       req,
   input  logic       channel_up,
   output logic       gt_reset,
   output logic       sys_reset,
   output logic       link_ok,
   output logic       busy,
   output logic [7:0] drop_cnt
`ifdef AURORA_RST_WATCHDOG_EN
   ,
   output logic       wd_retry
`endif
);

   typedef enum logic [1:0] {ST_PMA, ST_SYS, ST_WAIT, ST_UP} state_t;

   localparam logic [CNT_W-1:0] PMA_LAST = CNT_W'(PMA_HOLD - 1);
   localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_HOLD - 1);
`ifdef AURORA_RST_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(WD_TIMEOUT - 1);
`endif

   // Hold times must be non-zero and representable by the counter.
   generate
      if (PMA_HOLD < 1 || SYS_HOLD < 1 || WD_TIMEOUT < 1 ||
          PMA_HOLD > (1 << CNT_W) - 1 || SYS_HOLD > (1 << CNT_W) - 1 ||
          WD_TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_param
         $error("aurora_reset_sequencer: illegal hold/timeout parameter");
      end
   endgenerate

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [7:0]         drop_reg, drop_next;
   logic               timeout_next;
   logic               gt_next, sys_next, link_next, busy_next;
   logic               wd_reg;

   always_ff @(posedge CLK or posedge rst_in) begin
      if (rst_in) begin
         state_reg <= ST_PMA;
         cnt_reg   <= '0;
         drop_reg  <= '0;
         gt_reset  <= 1'b1;
         sys_reset <= 1'b1;
         link_ok   <= 1'b0;
         busy      <= 1'b1;
         wd_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         drop_reg  <= drop_next;
         gt_reset  <= gt_next;
         sys_reset <= sys_next;
         link_ok   <= link_next;
         busy      <= busy_next;
         wd_reg    <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      drop_next    = drop_reg;
      timeout_next = 1'b0;
      // A drop seen in UP is counted even when req pre-empts the WAIT transition.
      if (state_reg == ST_UP && !channel_up && drop_reg != 8'hFF)
         drop_next = drop_reg + 8'd1;
      if (req) begin
         state_next = ST_PMA;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            ST_PMA: begin
               if (cnt_reg == PMA_LAST) begin
                  state_next = ST_SYS;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_SYS: begin
               if (cnt_reg == SYS_LAST) begin
                  state_next = ST_WAIT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_WAIT: begin
               if (channel_up) begin
                  state_next = ST_UP;
                  cnt_next   = '0;
               end
`ifdef AURORA_RST_WATCHDOG_EN
               else if (cnt_reg == WD_LAST) begin
                  state_next   = ST_PMA;
                  cnt_next     = '0;
                  timeout_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
`endif
            end
            default: begin
               if (!channel_up) begin
                  state_next = ST_WAIT;
                  cnt_next   = '0;
               end
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they land in flops on the same edge.
   always_comb begin
      gt_next   = (state_next == ST_PMA);
      sys_next  = (state_next == ST_PMA) || (state_next == ST_SYS);
      link_next = (state_next == ST_UP);
      busy_next = (state_next != ST_UP);
   end

   assign drop_cnt = drop_reg;

`ifdef AURORA_RST_WATCHDOG_EN
   assign wd_retry = wd_reg;
`else
   logic unused_wd;
   assign unused_wd = wd_reg;
`endif

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// Randomized self-checking bench for aurora_reset_sequencer against a phase/elapsed-time model.
`timescale 1ns/1ps
module tb_aurora_reset_sequencer;

   localparam int PMA = 8;
   localparam int SYS = 4;
   localparam int WDT = 20;

   logic       CLK = 1'b0;
   logic       rst_in, req, channel_up;
   logic       gt_reset, sys_reset, link_ok, busy;
   logic [7:0] drop_cnt;
`ifdef AURORA_RST_WATCHDOG_EN
   logic       wd_retry;
`endif

   aurora_reset_sequencer #(.PMA_HOLD(PMA), .SYS_HOLD(SYS), .WD_TIMEOUT(WDT), .CNT_W(16)) dut (
      .CLK(CLK), .rst_in(rst_in), .req(req), .channel_up(channel_up),
      .gt_reset(gt_reset), .sys_reset(sys_reset), .link_ok(link_ok), .busy(busy),
      .drop_cnt(drop_cnt)
`ifdef AURORA_RST_WATCHDOG_EN
      , .wd_retry(wd_retry)
`endif
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   // Model: which phase we are in, edges spent in it, drop tally.
   int m_phase;   // 0 gt+core reset, 1 core reset only, 2 waiting for link, 3 link up
   int m_elapsed;
   int m_drop;
   int m_wd;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_elapsed = 0; m_drop = 0; m_wd = 0;
   endtask

   task automatic model_edge();
      if (rst_in) begin
         model_reset();
         return;
      end
      m_wd = 0;
      if (m_phase == 3 && !channel_up && m_drop < 255) m_drop++;
      if (req) begin
         m_phase = 0; m_elapsed = 0;
      end else if (m_phase == 0) begin
         m_elapsed++;
         if (m_elapsed == PMA) begin m_phase = 1; m_elapsed = 0; end
      end else if (m_phase == 1) begin
         m_elapsed++;
         if (m_elapsed == SYS) begin m_phase = 2; m_elapsed = 0; end
      end else if (m_phase == 2) begin
         if (channel_up) m_phase = 3;
`ifdef AURORA_RST_WATCHDOG_EN
         else begin
            m_elapsed++;
            if (m_elapsed == WDT) begin m_phase = 0; m_elapsed = 0; m_wd = 1; end
         end
`endif
      end else begin
         if (!channel_up) begin m_phase = 2; m_elapsed = 0; end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".gt"},   {7'd0, gt_reset},  {7'd0, 1'(m_phase == 0)});
      check({tag, ".sys"},  {7'd0, sys_reset}, {7'd0, 1'(m_phase <= 1)});
      check({tag, ".link"}, {7'd0, link_ok},   {7'd0, 1'(m_phase == 3)});
      check({tag, ".busy"}, {7'd0, busy},      {7'd0, 1'(m_phase != 3)});
      check({tag, ".drop"}, drop_cnt,          8'(m_drop));
`ifdef AURORA_RST_WATCHDOG_EN
      check({tag, ".wd"},   {7'd0, wd_retry},  8'(m_wd));
`endif
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic pulse_req(input string tag);
      req = 1'b1;
      step(tag);
      req = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; req = 1'b0; channel_up = 1'b0;
      model_reset();
      #1;
      compare_all("reset");
      run("reset_hold", 3);
      rst_in = 1'b0;

      // Power-up: gt for PMA edges, core alone for SYS edges, then waiting.
      run("powerup", PMA + SYS + 3);
      check("powerup_wait_busy", {7'd0, busy}, 8'd1);

      // Link up.
      channel_up = 1'b1;
      step("linkup");
      check("linkup_ok", {7'd0, link_ok}, 8'd1);
      run("up_hold", 3);

      // Three drops with return to UP in between.
      for (int d = 0; d < 3; d++) begin
         channel_up = 1'b0;
         step("drop");
         check("drop_link_low", {7'd0, link_ok}, 8'd0);
         check("drop_no_reset", {6'd0, gt_reset, sys_reset}, 8'd0);
         channel_up = 1'b1;
         run("reup", 2);
      end
      check("drop3", drop_cnt, 8'd3);

      // Saturation after many drops.
      for (int d = 0; d < 300; d++) begin
         channel_up = 1'b0;
         step("sat_drop");
         channel_up = 1'b1;
         step("sat_up");
      end
      check("drop_sat", drop_cnt, 8'd255);

      // Requests mid-PMA and mid-SYS restart the whole sequence.
      channel_up = 1'b0;
      pulse_req("req_up");
      run("req_pma", 5);
      pulse_req("req_mid_pma");
      run("req_pma2", PMA + 1);
      pulse_req("req_mid_sys");
      run("req_full", PMA + SYS + 2);
      check("req_drop_kept", drop_cnt, 8'd255);

      // Request while a drop happens in UP: counted, and sequence restarts.
      channel_up = 1'b1;
      run("pre_async_up", 2);
      channel_up = 1'b0;
      pulse_req("req_with_drop");
      channel_up = 1'b1;
      run("req_drop_seq", PMA + SYS + 3);

      // Asynchronous reset between edges while UP.
      #3;
      rst_in = 1'b1;
      #1;
      model_reset();
      compare_all("async");
      run("async_hold", 2);
      #2;
      rst_in = 1'b0;
      channel_up = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         req = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) channel_up = ~channel_up;
         step("rand");
      end
      req = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
